// File: rtl/crc_frame_pkg.sv
// crc_frame_pkg: shared types, constants and the byte-wise Modbus CRC step for crc_frame_sched.
// Contents: state_t (sequencer states), CRC_INIT/CRC_POLY/CRC_RESIDUE_OK, grant encodings,
// crc16_byte() which folds one byte into a running reflected CRC-16 (poly 0xA001).
package crc_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RX_RUN,
        RX_CHK,
        TX_RUN,
        TX_CRC_LO,
        TX_CRC_HI
    } state_t;

    localparam logic [15:0] CRC_INIT       = 16'hFFFF;
    localparam logic [15:0] CRC_POLY       = 16'hA001;
    localparam logic [15:0] CRC_RESIDUE_OK = 16'h0000;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_RX   = 2'b01;
    localparam logic [1:0] GNT_TX   = 2'b10;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] r;
        r = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

endpackage

// File: rtl/crc_frame_sched_crc_16.sv
// crc_16: byte-wise Modbus CRC-16 engine (init 0xFFFF, reflected poly 0xA001).
// Ports: clk, rst_n (async, active-low), crc_en (fold data_in this cycle),
// crc_clr (reload CRC_INIT, wins over crc_en), data_in[7:0], crc_out[15:0] (running CRC).
module crc_16
    import crc_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_en,
    input  logic        crc_clr,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            crc_out <= CRC_INIT;
        else if (crc_clr)
            crc_out <= CRC_INIT;
        else if (crc_en)
            crc_out <= crc16_byte(crc_out, data_in);

endmodule

// File: rtl/crc_frame_sched.sv
// crc_frame_sched: frame-level arbiter/sequencer sharing one crc_16 between an RX checker and a TX builder.
// Ports: tb_clk, tb_rst_n (async, active-low);
//   RX side  : rx_valid/rx_data/rx_last in, rx_ready out, verdict rx_done/rx_crc_ok/rx_len_err out;
//   TX side  : tx_valid/tx_data/tx_last in, tx_ready out;
//   TX output: tx_out_valid/tx_out_data/tx_out_last out, tx_out_ready in;
//   grant    : one-hot frame owner (bit0 RX, bit1 TX, 00 idle).
module crc_frame_sched
    import crc_frame_pkg::*;
#(
    parameter int MAX_LEN    = 256,
    parameter int RX_MIN_LEN = 4
) (
    input  logic       tb_clk,
    input  logic       tb_rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_last,
    output logic       rx_ready,
    output logic       rx_done,
    output logic       rx_crc_ok,
    output logic       rx_len_err,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_out_valid,
    output logic [7:0] tx_out_data,
    output logic       tx_out_last,
    input  logic       tx_out_ready,
    output logic [1:0] grant
);

    // Counter is wide enough to hold the saturation value MAX_LEN+1.
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [LW-1:0] LEN_MIN = LW'(RX_MIN_LEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LEN + 1);

    state_t        state, state_nx;
    logic          prio_tx;
    logic [LW-1:0] len;
    logic          rx_acc, tx_acc, len_bad;
    logic          crc_en, crc_clr;
    logic [7:0]    crc_din;
    logic [15:0]   crc_out;

    assign rx_acc  = (state == RX_RUN) & rx_valid;
    assign tx_acc  = (state == TX_RUN) & tx_valid & tx_out_ready;
    assign len_bad = (len < LEN_MIN) | (len > LEN_MAX);

    crc_16 u_crc (
        .clk     (tb_clk),
        .rst_n   (tb_rst_n),
        .crc_en  (crc_en),
        .crc_clr (crc_clr),
        .data_in (crc_din),
        .crc_out (crc_out)
    );

    always_ff @(posedge tb_clk or negedge tb_rst_n)
        if (!tb_rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = (rx_valid | tx_valid) ? CLR : IDLE;
            CLR:       state_nx = (grant == GNT_RX) ? RX_RUN : TX_RUN;
            RX_RUN:    state_nx = (rx_acc & rx_last) ? RX_CHK : RX_RUN;
            RX_CHK:    state_nx = IDLE;
            TX_RUN:    state_nx = (tx_acc & tx_last) ? TX_CRC_LO : TX_RUN;
            TX_CRC_LO: state_nx = tx_out_ready ? TX_CRC_HI : TX_CRC_LO;
            TX_CRC_HI: state_nx = tx_out_ready ? IDLE : TX_CRC_HI;
            default:   state_nx = IDLE;
        endcase
    end

    // Round-robin only advances on contention; a lone requester does not move priority.
    always_ff @(posedge tb_clk or negedge tb_rst_n)
        if (!tb_rst_n) begin
            grant   <= GNT_NONE;
            prio_tx <= 1'b0;
            len     <= '0;
        end else begin
            if (state == IDLE && (rx_valid | tx_valid)) begin
                grant <= (rx_valid & (~tx_valid | ~prio_tx)) ? GNT_RX : GNT_TX;
                if (rx_valid & tx_valid)
                    prio_tx <= ~prio_tx;
            end else if (state_nx == IDLE)
                grant <= GNT_NONE;
            if (state == CLR)
                len <= '0;
            else if (rx_acc && len != LEN_SAT)
                len <= len + 1'b1;
        end

    always_comb begin
        rx_ready     = state == RX_RUN;
        tx_ready     = (state == TX_RUN) & tx_out_ready;
        rx_done      = state == RX_CHK;
        rx_len_err   = rx_done & len_bad;
        rx_crc_ok    = rx_done & (crc_out == CRC_RESIDUE_OK) & ~len_bad;
        tx_out_valid = (state == TX_RUN) ? tx_valid : (state == TX_CRC_LO) | (state == TX_CRC_HI);
        tx_out_data  = (state == TX_RUN)    ? tx_data       :
                       (state == TX_CRC_LO) ? crc_out[7:0]  :
                       (state == TX_CRC_HI) ? crc_out[15:8] : 8'h00;
        tx_out_last  = state == TX_CRC_HI;
        crc_clr      = state == CLR;
        crc_en       = rx_acc | tx_acc;
        crc_din      = (state == TX_RUN) ? tx_data : rx_data;
    end

endmodule

// File: tb/tb_crc_frame_sched.sv
// tb_crc_frame_sched: scoreboard bench for crc_frame_sched; drivers push expected verdicts/bytes, a monitor pops and compares.
module tb_crc_frame_sched;

    logic       tb_clk = 1'b0;
    logic       tb_rst_n = 1'b0;
    logic       rx_valid = 1'b0, rx_last = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] rx_data = 8'h00, tx_data = 8'h00;
    logic       tx_out_ready;
    logic       rx_ready, rx_done, rx_crc_ok, rx_len_err, tx_ready;
    logic       tx_out_valid, tx_out_last;
    logic [7:0] tx_out_data;
    logic [1:0] grant;

    int total = 0;
    int bad = 0;
    logic       tog = 1'b0;
    logic [1:0] rx_q[$];
    logic [8:0] tx_q[$];
    logic [7:0] f[$], t[$], lng[$];

    crc_frame_sched dut (
        .tb_clk       (tb_clk),
        .tb_rst_n     (tb_rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_last      (rx_last),
        .rx_ready     (rx_ready),
        .rx_done      (rx_done),
        .rx_crc_ok    (rx_crc_ok),
        .rx_len_err   (rx_len_err),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .tx_out_valid (tx_out_valid),
        .tx_out_data  (tx_out_data),
        .tx_out_last  (tx_out_last),
        .tx_out_ready (tx_out_ready),
        .grant        (grant)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    initial begin
        tx_out_ready = 1'b1;
        forever begin
            @(posedge tb_clk);
            #1 tx_out_ready = tog ? ~tx_out_ready : 1'b1;
        end
    end

    // Monitor: peek at every offered TX byte (checks hold-stability too), pop on accept.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge tb_clk);
            if (tb_rst_n) begin
                if (rx_done) begin
                    if (rx_q.size() == 0)
                        fail("rx_unexpected_done");
                    else begin
                        e = rx_q.pop_front();
                        chk("rx_verdict{ok,len_err}", {rx_crc_ok, rx_len_err}, e);
                    end
                end
                if (tx_out_valid) begin
                    if (tx_q.size() == 0)
                        fail("tx_unexpected_byte");
                    else begin
                        chk("tx_out{last,data}", {tx_out_last, tx_out_data}, tx_q[0]);
                        if (tx_out_ready)
                            void'(tx_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic rx_send(input logic [7:0] b[$], input logic ok, input logic le);
        logic acc;
        int   n;
        rx_q.push_back({ok, le});
        foreach (b[i]) begin
            rx_valid = 1'b1;
            rx_data  = b[i];
            rx_last  = (i == b.size() - 1);
            n = 0;
            do begin
                @(negedge tb_clk);
                acc = rx_ready;
                @(posedge tb_clk);
                #1 n++;
            end while (!acc && n < 400);
            if (!acc) begin
                fail("rx_accept_timeout");
                rx_valid = 1'b0;
                rx_last  = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        @(negedge tb_clk);
        chk("rx_done_latency", rx_done, 1);
    endtask

    task automatic tx_send(input logic [7:0] b[$], input logic [7:0] lo, input logic [7:0] hi, input int stop);
        logic acc;
        int   n;
        foreach (b[i]) begin
            if (stop != 0 && i == stop) begin
                tx_valid = 1'b0;
                return;
            end
            tx_q.push_back({1'b0, b[i]});
            tx_valid = 1'b1;
            tx_data  = b[i];
            tx_last  = (i == b.size() - 1);
            n = 0;
            do begin
                @(negedge tb_clk);
                acc = tx_valid & tx_ready;
                @(posedge tb_clk);
                #1 n++;
            end while (!acc && n < 400);
            if (!acc) begin
                fail("tx_accept_timeout");
                tx_valid = 1'b0;
                tx_last  = 1'b0;
                return;
            end
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_q.push_back({1'b0, lo});
        tx_q.push_back({1'b1, hi});
        @(negedge tb_clk);
        chk("tx_crc_lo_next_cycle", {tx_out_valid, tx_out_data}, {1'b1, lo});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0 || grant != 2'b00) && n < 500) begin
            @(posedge tb_clk);
            #1 n++;
        end
        if (n >= 500)
            fail("idle_timeout");
        repeat (2) @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        tb_rst_n = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1 tb_rst_n = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
    endtask

    initial begin
        logic held;
        int   n;
        #1;
        chk("reset_outputs", {grant, rx_ready, rx_done, rx_crc_ok, rx_len_err, tx_ready,
                              tx_out_valid, tx_out_data, tx_out_last}, 0);
        do_reset();

        f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        t = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};

        rx_send(f, 1'b1, 1'b0);
        wait_idle();
        f[7] = 8'h0B;
        rx_send(f, 1'b0, 1'b0);
        wait_idle();
        f[7] = 8'h0A;

        tog = 1'b1;
        tx_send(t, 8'h84, 8'h0A, 0);
        wait_idle();
        tog = 1'b0;

        lng = '{8'h01, 8'h03, 8'h0A};
        rx_send(lng, 1'b0, 1'b1);
        wait_idle();
        lng.delete();
        for (int i = 0; i < 257; i++)
            lng.push_back(8'h00);
        rx_send(lng, 1'b0, 1'b1);
        wait_idle();

        do_reset();
        fork
            rx_send(f, 1'b1, 1'b0);
            tx_send(t, 8'h84, 8'h0A, 0);
            begin
                n = 0;
                while (grant == 2'b00 && n < 50) begin
                    @(negedge tb_clk);
                    n++;
                end
                chk("contention1_grant", grant, 2'b01);
                held = 1'b1;
                n = 0;
                while (!rx_done && n < 100) begin
                    if (tx_ready)
                        held = 1'b0;
                    @(negedge tb_clk);
                    n++;
                end
                chk("contention1_tx_held_off", {rx_done, held}, 2'b11);
            end
        join
        wait_idle();
        fork
            rx_send(f, 1'b1, 1'b0);
            tx_send(t, 8'h84, 8'h0A, 0);
            begin
                n = 0;
                while (grant == 2'b00 && n < 50) begin
                    @(negedge tb_clk);
                    n++;
                end
                chk("contention2_grant", grant, 2'b10);
                held = 1'b1;
                n = 0;
                while (!(tx_out_last & tx_out_ready) && n < 100) begin
                    if (rx_ready)
                        held = 1'b0;
                    @(negedge tb_clk);
                    n++;
                end
                chk("contention2_rx_held_off", {tx_out_last, held}, 2'b11);
            end
        join
        wait_idle();

        tx_send(t, 8'h84, 8'h0A, 3);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        #1 chk("abort_passthrough_before_reset", {tx_out_valid, grant}, {1'b1, 2'b10});
        #1 tb_rst_n = 1'b0;
        #1 chk("abort_async_outputs", {grant, rx_ready, rx_done, rx_crc_ok, rx_len_err, tx_ready,
                                       tx_out_valid, tx_out_data, tx_out_last}, 0);
        tx_valid = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1 chk("abort_queue_drained", tx_q.size(), 0);
        tb_rst_n = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1 tog = 1'b1;
        tx_send(t, 8'h84, 8'h0A, 0);
        wait_idle();
        tog = 1'b0;

        chk("rx_queue_empty", rx_q.size(), 0);
        chk("tx_queue_empty", tx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
